// File: rtl/mips_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared constants for the multicycle MIPS main control:
//   - state encodings (also visible on the estado debug port)
//   - opcode constants for the supported instructions
//   - OpALU codes and the OrigBALU / OrigPC mux select codes
// ---------------------------------------------------------------------------
package mips_ctrl_pkg;

    // State encodings
    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_MEMADR = 4'd3;
    localparam logic [3:0] S_MEMRD  = 4'd4;
    localparam logic [3:0] S_MEMWB  = 4'd5;
    localparam logic [3:0] S_MEMWR  = 4'd6;
    localparam logic [3:0] S_RTYPE  = 4'd7;
    localparam logic [3:0] S_RWB    = 4'd8;
    localparam logic [3:0] S_BEQ    = 4'd9;
    localparam logic [3:0] S_JUMP   = 4'd10;
    localparam logic [3:0] S_ADDI   = 4'd11;
    localparam logic [3:0] S_IWB    = 4'd12;

    // Opcode constants (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // OpALU codes sent to the ALU control block
    localparam logic [1:0] OPALU_ADD   = 2'b00;
    localparam logic [1:0] OPALU_SUB   = 2'b01;
    localparam logic [1:0] OPALU_FUNCT = 2'b10;

    // ALU B operand select
    localparam logic [1:0] BSEL_REGB   = 2'b00;
    localparam logic [1:0] BSEL_FOUR   = 2'b01;
    localparam logic [1:0] BSEL_SEXT   = 2'b10;
    localparam logic [1:0] BSEL_SEXTSH = 2'b11;

    // PC source select
    localparam logic [1:0] PCSEL_ALU    = 2'b00;
    localparam logic [1:0] PCSEL_ALUOUT = 2'b01;
    localparam logic [1:0] PCSEL_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm
// Main control for a multicycle MIPS datapath. Walks each instruction through
// FETCH / DECODE / EXEC / MEM / WB and drives the shared-datapath mux selects
// and write strobes. Memory states optionally stall on mem_ready.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   opcode            IR[31:26], looked at in DECODE and MEMADR
//   mem_ready         memory access completes this cycle
//   EscrevePC         unconditional PC write
//   EscrevePCCond     PC write if ALU zero (beq)
//   IouD              memory address select: 0=PC, 1=ALUOut
//   LeMem, EscreveMem memory read / write strobes
//   EscreveIR         instruction register load
//   MemparaReg        write-back source: 0=ALUOut, 1=MDR
//   RegDst            destination register: 0=rt, 1=rd
//   EscreveReg        register-file write
//   OrigAALU          ALU A select: 0=PC, 1=A
//   OrigBALU          ALU B select: 00=B, 01=4, 10=signext, 11=signext<<2
//   OpALU             operation class for the ALU control block
//   OrigPC            PC source: 00=ALU, 01=ALUOut, 10=jump target
//   ilegal            high during the DECODE cycle of an unsupported opcode
//   estado            current state code
// ---------------------------------------------------------------------------
module multicycle_control_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int OPALU_W  = 2,
    parameter bit MEM_HS   = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                EscrevePC,
    output logic                EscrevePCCond,
    output logic                IouD,
    output logic                LeMem,
    output logic                EscreveMem,
    output logic                EscreveIR,
    output logic                MemparaReg,
    output logic                RegDst,
    output logic                EscreveReg,
    output logic                OrigAALU,
    output logic [1:0]          OrigBALU,
    output logic [OPALU_W-1:0]  OpALU,
    output logic [1:0]          OrigPC,
    output logic                ilegal,
    output logic [3:0]          estado
);

    logic [3:0] state;
    logic [3:0] nextState;
    logic       memReady;

    // Without the handshake every memory access is assumed to finish in one cycle.
    assign memReady = MEM_HS ? mem_ready : 1'b1;

    assign estado = state;

    // State register. Because every output is decoded from this register,
    // asserting reset drops all strobes in the same instant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state and output decode. Outputs follow the registered state; the
    // strobes of the wait states (FETCH, MEMWR) are also gated by memReady so a
    // write only lands in the cycle the memory completes.
    always_comb begin
        nextState     = S_FETCH;
        EscrevePC     = 1'b0;
        EscrevePCCond = 1'b0;
        IouD          = 1'b0;
        LeMem         = 1'b0;
        EscreveMem    = 1'b0;
        EscreveIR     = 1'b0;
        MemparaReg    = 1'b0;
        RegDst        = 1'b0;
        EscreveReg    = 1'b0;
        OrigAALU      = 1'b0;
        OrigBALU      = BSEL_REGB;
        OpALU         = '0;
        OrigPC        = PCSEL_ALU;
        ilegal        = 1'b0;

        case (state)
            S_IDLE: begin
                nextState = S_FETCH;
            end
            S_FETCH: begin
                LeMem     = 1'b1;
                OrigBALU  = BSEL_FOUR;
                OpALU     = OPALU_W'(OPALU_ADD);
                EscreveIR = memReady;
                EscrevePC = memReady;
                nextState = memReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // ALUOut <= PC + (signext << 2) so BEQ finds its target ready.
                OrigBALU = BSEL_SEXTSH;
                OpALU    = OPALU_W'(OPALU_ADD);
                if (opcode == OPCODE_W'(OP_RTYPE)) begin
                    nextState = S_RTYPE;
                end else if (opcode == OPCODE_W'(OP_LW) || opcode == OPCODE_W'(OP_SW)) begin
                    nextState = S_MEMADR;
                end else if (opcode == OPCODE_W'(OP_BEQ)) begin
                    nextState = S_BEQ;
                end else if (opcode == OPCODE_W'(OP_J)) begin
                    nextState = S_JUMP;
                end else if (opcode == OPCODE_W'(OP_ADDI)) begin
                    nextState = S_ADDI;
                end else begin
                    nextState = S_FETCH;
                    ilegal    = 1'b1;
                end
            end
            S_MEMADR: begin
                OrigAALU = 1'b1;
                OrigBALU = BSEL_SEXT;
                OpALU    = OPALU_W'(OPALU_ADD);
                // The IR still holds the lw/sw opcode here; anything else
                // cannot reach this state, so fall back to FETCH.
                if (opcode == OPCODE_W'(OP_LW)) begin
                    nextState = S_MEMRD;
                end else if (opcode == OPCODE_W'(OP_SW)) begin
                    nextState = S_MEMWR;
                end else begin
                    nextState = S_FETCH;
                end
            end
            S_MEMRD: begin
                LeMem     = 1'b1;
                IouD      = 1'b1;
                nextState = memReady ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                EscreveReg = 1'b1;
                MemparaReg = 1'b1;
                nextState  = S_FETCH;
            end
            S_MEMWR: begin
                EscreveMem = memReady;
                IouD       = 1'b1;
                nextState  = memReady ? S_FETCH : S_MEMWR;
            end
            S_RTYPE: begin
                OrigAALU  = 1'b1;
                OrigBALU  = BSEL_REGB;
                OpALU     = OPALU_W'(OPALU_FUNCT);
                nextState = S_RWB;
            end
            S_RWB: begin
                EscreveReg = 1'b1;
                RegDst     = 1'b1;
                nextState  = S_FETCH;
            end
            S_BEQ: begin
                OrigAALU      = 1'b1;
                OpALU         = OPALU_W'(OPALU_SUB);
                EscrevePCCond = 1'b1;
                OrigPC        = PCSEL_ALUOUT;
                nextState     = S_FETCH;
            end
            S_JUMP: begin
                EscrevePC = 1'b1;
                OrigPC    = PCSEL_JUMP;
                nextState = S_FETCH;
            end
            S_ADDI: begin
                OrigAALU  = 1'b1;
                OrigBALU  = BSEL_SEXT;
                OpALU     = OPALU_W'(OPALU_ADD);
                nextState = S_IWB;
            end
            S_IWB: begin
                EscreveReg = 1'b1;
                nextState  = S_FETCH;
            end
            default: begin
                nextState = S_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control_fsm
// Directed bench for the multicycle main control. Each step drives opcode and
// mem_ready mid-cycle, pushes the expected state and control word onto a
// scoreboard queue, and pops/compares it against the DUT shortly afterwards.
// ---------------------------------------------------------------------------
module tb_multicycle_control_fsm;

    typedef struct packed {
        logic       escrevePC;
        logic       escrevePCCond;
        logic       iouD;
        logic       leMem;
        logic       escreveMem;
        logic       escreveIR;
        logic       memparaReg;
        logic       regDst;
        logic       escreveReg;
        logic       origAALU;
        logic [1:0] origBALU;
        logic [1:0] opALU;
        logic [1:0] origPC;
        logic       ilegal;
    } ctrlWord_t;

    typedef struct packed {
        logic [3:0] estado;
        ctrlWord_t  ctrl;
    } expect_t;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       EscrevePC, EscrevePCCond, IouD, LeMem, EscreveMem, EscreveIR;
    logic       MemparaReg, RegDst, EscreveReg, OrigAALU, ilegal;
    logic [1:0] OrigBALU, OpALU, OrigPC;
    logic [3:0] estado;

    int checks   = 0;
    int failures = 0;
    expect_t scoreboard[$];

    multicycle_control_fsm #(.OPCODE_W(6), .OPALU_W(2), .MEM_HS(1'b1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode       (opcode),
        .mem_ready    (mem_ready),
        .EscrevePC    (EscrevePC),
        .EscrevePCCond(EscrevePCCond),
        .IouD         (IouD),
        .LeMem        (LeMem),
        .EscreveMem   (EscreveMem),
        .EscreveIR    (EscreveIR),
        .MemparaReg   (MemparaReg),
        .RegDst       (RegDst),
        .EscreveReg   (EscreveReg),
        .OrigAALU     (OrigAALU),
        .OrigBALU     (OrigBALU),
        .OpALU        (OpALU),
        .OrigPC       (OrigPC),
        .ilegal       (ilegal),
        .estado       (estado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected control word for a given state, written from the state table.
    function automatic ctrlWord_t expectFor(input logic [3:0] s, input logic r, input logic [5:0] op);
        ctrlWord_t c;
        c = '0;
        case (s)
            4'd1:  begin c.leMem = 1'b1; c.origBALU = 2'b01; c.escreveIR = r; c.escrevePC = r; end
            4'd2:  begin
                       c.origBALU = 2'b11;
                       c.ilegal = !(op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
                                    op == 6'b000100 || op == 6'b000010 || op == 6'b001000);
                   end
            4'd3:  begin c.origAALU = 1'b1; c.origBALU = 2'b10; end
            4'd4:  begin c.leMem = 1'b1; c.iouD = 1'b1; end
            4'd5:  begin c.escreveReg = 1'b1; c.memparaReg = 1'b1; end
            4'd6:  begin c.escreveMem = r; c.iouD = 1'b1; end
            4'd7:  begin c.origAALU = 1'b1; c.opALU = 2'b10; end
            4'd8:  begin c.escreveReg = 1'b1; c.regDst = 1'b1; end
            4'd9:  begin c.origAALU = 1'b1; c.opALU = 2'b01; c.escrevePCCond = 1'b1; c.origPC = 2'b01; end
            4'd10: begin c.escrevePC = 1'b1; c.origPC = 2'b10; end
            4'd11: begin c.origAALU = 1'b1; c.origBALU = 2'b10; end
            4'd12: begin c.escreveReg = 1'b1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Pop the oldest expectation and compare it with what the DUT shows now.
    task automatic checkOutput(input string tag);
        expect_t   e;
        ctrlWord_t got;
        got = '{EscrevePC, EscrevePCCond, IouD, LeMem, EscreveMem, EscreveIR, MemparaReg,
                RegDst, EscreveReg, OrigAALU, OrigBALU, OpALU, OrigPC, ilegal};
        if (scoreboard.size() == 0) begin
            checks++;
            failures++;
            $error("[TB] FAIL %s: scoreboard empty, observed estado=%0d", tag, estado);
            return;
        end
        e = scoreboard.pop_front();
        checks++;
        assert (estado === e.estado) else begin
            failures++;
            $error("[TB] FAIL %s.estado: observed=%0d expected=%0d", tag, estado, e.estado);
        end
        checks++;
        assert (got === e.ctrl) else begin
            failures++;
            $error("[TB] FAIL %s.ctrl: observed=%b expected=%b", tag, got, e.ctrl);
        end
    endtask

    // Drive one mid-cycle step, check the current state, then move one clock on.
    task automatic applyStimulus(input string tag, input logic r, input logic [5:0] op,
                                 input logic [3:0] expState);
        expect_t e;
        mem_ready = r;
        opcode    = op;
        e.estado  = expState;
        e.ctrl    = expectFor(expState, r, op);
        scoreboard.push_back(e);
        #1;
        checkOutput(tag);
        @(negedge clk);
    endtask

    // Assert reset mid-cycle and expect everything to clear without a clock edge.
    task automatic applyReset(input string tag);
        expect_t e;
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        e         = '0;
        scoreboard.push_back(e);
        #1;
        checkOutput(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BQ = 6'b000100, JJ = 6'b000010, AI = 6'b001000, BAD = 6'b111111;

    initial begin
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        opcode    = 6'b000000;
        repeat (2) @(negedge clk);
        $display("[TB] reset release");
        rst_n = 1'b1;
        applyStimulus("idle", 1'b1, RT, 4'd0);
        applyStimulus("fetch", 1'b1, LW, 4'd1);

        $display("[TB] lw");
        applyStimulus("lw.decode", 1'b1, LW, 4'd2);
        applyStimulus("lw.memadr", 1'b1, LW, 4'd3);
        applyStimulus("lw.memrd", 1'b1, LW, 4'd4);
        applyStimulus("lw.memwb", 1'b1, LW, 4'd5);

        $display("[TB] sw with stall");
        applyStimulus("sw.fetch", 1'b1, SW, 4'd1);
        applyStimulus("sw.decode", 1'b1, SW, 4'd2);
        applyStimulus("sw.memadr", 1'b1, SW, 4'd3);
        applyStimulus("sw.stall0", 1'b0, SW, 4'd6);
        applyStimulus("sw.stall1", 1'b0, SW, 4'd6);
        applyStimulus("sw.stall2", 1'b0, SW, 4'd6);
        applyStimulus("sw.memwr", 1'b1, SW, 4'd6);

        $display("[TB] r-type with fetch stall");
        applyStimulus("rt.fetchStall", 1'b0, RT, 4'd1);
        applyStimulus("rt.fetch", 1'b1, RT, 4'd1);
        applyStimulus("rt.decode", 1'b1, RT, 4'd2);
        applyStimulus("rt.exec", 1'b1, RT, 4'd7);
        applyStimulus("rt.rwb", 1'b1, RT, 4'd8);

        $display("[TB] beq / j");
        applyStimulus("beq.fetch", 1'b1, BQ, 4'd1);
        applyStimulus("beq.decode", 1'b1, BQ, 4'd2);
        applyStimulus("beq.exec", 1'b1, BQ, 4'd9);
        applyStimulus("j.fetch", 1'b1, JJ, 4'd1);
        applyStimulus("j.decode", 1'b1, JJ, 4'd2);
        applyStimulus("j.exec", 1'b1, JJ, 4'd10);

        $display("[TB] illegal opcode");
        applyStimulus("bad.fetch", 1'b1, BAD, 4'd1);
        applyStimulus("bad.decode", 1'b1, BAD, 4'd2);
        applyStimulus("bad.after", 1'b1, BAD, 4'd1);

        $display("[TB] reset mid-MEMRD");
        applyStimulus("lw2.decode", 1'b0, LW, 4'd2);
        applyStimulus("lw2.memadr", 1'b0, LW, 4'd3);
        applyStimulus("lw2.memrdStall", 1'b0, LW, 4'd4);
        applyReset("rst.memrd");
        applyStimulus("rst.idle", 1'b1, AI, 4'd0);
        applyStimulus("rst.fetch", 1'b1, AI, 4'd1);

        $display("[TB] addi and reset mid-IWB");
        applyStimulus("addi.decode", 1'b1, AI, 4'd2);
        applyStimulus("addi.exec", 1'b1, AI, 4'd11);
        applyStimulus("addi.iwbPre", 1'b1, AI, 4'd12);
        applyStimulus("addi.fetch", 1'b1, AI, 4'd1);
        applyStimulus("addi2.decode", 1'b1, AI, 4'd2);
        applyStimulus("addi2.exec", 1'b1, AI, 4'd11);
        mem_ready = 1'b1;
        #1;
        applyReset("rst.iwb");
        applyStimulus("rst2.idle", 1'b1, RT, 4'd0);
        applyStimulus("rst2.fetch", 1'b1, RT, 4'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
